// File: rtl/multi_alarm_clock_if.sv
// Signal bundle between the switch/key front end and the alarm clock core.
// SNOOZE_EN adds the snooze level input.
interface multi_alarm_clock_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
  logic                  run;
  logic                  time_set;
  logic                  alarm_set;
  logic                  set_hr;
  logic [IDX_W-1:0]      alarm_idx;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  alarm_ack;
`ifdef SNOOZE_EN
  logic                  snooze;
`endif
  logic [5:0]            sec;
  logic [5:0]            min;
  logic [4:0]            hrs;
  logic [5:0]            a_min;
  logic [4:0]            a_hrs;
  logic [NUM_ALARMS-1:0] ringing;
  logic                  alarm_out;
  logic                  tick_1hz;

  modport master (
    output run, time_set, alarm_set, set_hr, alarm_idx, alarm_en, alarm_ack,
`ifdef SNOOZE_EN
    output snooze,
`endif
    input  sec, min, hrs, a_min, a_hrs, ringing, alarm_out, tick_1hz
  );

  modport slave (
    input  run, time_set, alarm_set, set_hr, alarm_idx, alarm_en, alarm_ack,
`ifdef SNOOZE_EN
    input  snooze,
`endif
    output sec, min, hrs, a_min, a_hrs, ringing, alarm_out, tick_1hz
  );
endinterface

// File: rtl/multi_alarm_clock.sv
// 24-hour clock with NUM_ALARMS alarms, single clock domain with tick enables.
// Optional snooze support is enabled with `define SNOOZE_EN.
module multi_alarm_clock #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SET_RATE_HZ = 2,
  parameter int NUM_ALARMS  = 4,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  multi_alarm_clock_if.slave bus
);
  localparam int SET_DIV = (CLK_HZ / SET_RATE_HZ > 0) ? CLK_HZ / SET_RATE_HZ : 1;
  localparam int CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SET_W   = (SET_DIV > 1) ? $clog2(SET_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SET_DIV - 1);

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  logic [CNT_W-1:0]      cnt_q;
  logic [SET_W-1:0]      set_cnt_q;
  logic                  tick, set_tick, rollover, idx_ok;
  logic [5:0]            sec_q, sec_d, min_q, min_d, a_min_q, a_min_d;
  logic [4:0]            hrs_q, hrs_d, a_hrs_q, a_hrs_d;
  logic [5:0]            al_min_q [NUM_ALARMS];
  logic [5:0]            al_min_d [NUM_ALARMS];
  logic [4:0]            al_hrs_q [NUM_ALARMS];
  logic [4:0]            al_hrs_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match_q, match_d, ring_q, ring_d;
  logic                  alarm_out_q, tick_q;
`ifdef SNOOZE_EN
  logic [NUM_ALARMS-1:0] pend_q, pend_d;
  logic [5:0]            snz_min_q [NUM_ALARMS];
  logic [5:0]            snz_min_d [NUM_ALARMS];
  logic [4:0]            snz_hrs_q [NUM_ALARMS];
  logic [4:0]            snz_hrs_d [NUM_ALARMS];
  logic [6:0]            snz_sum;
  logic [5:0]            tgt_min;
  logic [4:0]            tgt_hrs;
`endif

  assign tick     = (cnt_q == CNT_LAST);
  assign set_tick = (set_cnt_q == SET_LAST);
  assign idx_ok   = int'(bus.alarm_idx) < NUM_ALARMS;

`ifdef SNOOZE_EN
  // Snooze target is taken from the time currently on display, wrapped over midnight.
  assign snz_sum = {1'b0, min_q} + 7'(SNOOZE_MIN);
  assign tgt_min = (snz_sum >= 7'd60) ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
  assign tgt_hrs = (snz_sum >= 7'd60) ? inc24(hrs_q) : hrs_q;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hrs_d    = hrs_q;
    al_min_d = al_min_q;
    al_hrs_d = al_hrs_q;
    rollover = 1'b0;
    match_d  = '0;
    ring_d   = ring_q;
`ifdef SNOOZE_EN
    pend_d    = pend_q;
    snz_min_d = snz_min_q;
    snz_hrs_d = snz_hrs_q;
`endif

    if (bus.time_set) begin
      sec_d = 6'd0;
      if (set_tick) begin
        if (bus.set_hr) hrs_d = inc24(hrs_q);
        else            min_d = inc60(min_q);
      end
    end else begin
      if (bus.alarm_set && set_tick && idx_ok) begin
        if (bus.set_hr) al_hrs_d[bus.alarm_idx] = inc24(al_hrs_q[bus.alarm_idx]);
        else            al_min_d[bus.alarm_idx] = inc60(al_min_q[bus.alarm_idx]);
      end
      if (bus.run && tick) begin
        sec_d = inc60(sec_q);
        if (sec_q == 6'd59) begin
          rollover = 1'b1;
          min_d    = inc60(min_q);
          if (min_q == 6'd59) hrs_d = inc24(hrs_q);
        end
      end
    end

    for (int i = 0; i < NUM_ALARMS; i++) begin
      match_d[i] = bus.alarm_en[i] && rollover &&
                   al_min_q[i] == min_d && al_hrs_q[i] == hrs_d;
`ifdef SNOOZE_EN
      if (bus.alarm_en[i] && rollover && pend_q[i] &&
          snz_min_q[i] == min_d && snz_hrs_q[i] == hrs_d) begin
        match_d[i] = 1'b1;
        pend_d[i]  = 1'b0;
      end
`endif
      // Ack clears everything, but a match registered last cycle still lands.
      if (bus.alarm_ack) begin
        ring_d[i] = 1'b0;
`ifdef SNOOZE_EN
        pend_d[i] = 1'b0;
      end else if (bus.snooze && ring_q[i]) begin
        ring_d[i]    = 1'b0;
        pend_d[i]    = 1'b1;
        snz_min_d[i] = tgt_min;
        snz_hrs_d[i] = tgt_hrs;
`endif
      end
      if (match_q[i]) ring_d[i] = 1'b1;
      if (!bus.alarm_en[i]) begin
        ring_d[i] = 1'b0;
`ifdef SNOOZE_EN
        pend_d[i] = 1'b0;
`endif
      end
    end

    a_min_d = idx_ok ? al_min_d[bus.alarm_idx] : 6'd0;
    a_hrs_d = idx_ok ? al_hrs_d[bus.alarm_idx] : 5'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      set_cnt_q   <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hrs_q       <= '0;
      a_min_q     <= '0;
      a_hrs_q     <= '0;
      match_q     <= '0;
      ring_q      <= '0;
      alarm_out_q <= 1'b0;
      tick_q      <= 1'b0;
      // NOTE: the alarm table is a handful of flops that must read 00:00 after reset, so it is reset like any register.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_min_q[i] <= '0;
        al_hrs_q[i] <= '0;
`ifdef SNOOZE_EN
        snz_min_q[i] <= '0;
        snz_hrs_q[i] <= '0;
`endif
      end
`ifdef SNOOZE_EN
      pend_q <= '0;
`endif
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + 1'b1;
      set_cnt_q   <= set_tick ? '0 : set_cnt_q + 1'b1;
      tick_q      <= tick;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hrs_q       <= hrs_d;
      al_min_q    <= al_min_d;
      al_hrs_q    <= al_hrs_d;
      a_min_q     <= a_min_d;
      a_hrs_q     <= a_hrs_d;
      match_q     <= match_d;
      ring_q      <= ring_d;
      alarm_out_q <= |ring_d;
`ifdef SNOOZE_EN
      pend_q    <= pend_d;
      snz_min_q <= snz_min_d;
      snz_hrs_q <= snz_hrs_d;
`endif
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hrs       = hrs_q;
  assign bus.a_min     = a_min_q;
  assign bus.a_hrs     = a_hrs_q;
  assign bus.ringing   = ring_q;
  assign bus.alarm_out = alarm_out_q;
  assign bus.tick_1hz  = tick_q;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock at CLK_HZ=4, SET_RATE_HZ=2, four alarms.
// Hold windows are multiples of the prescaler periods, so step counts are exact.
module tb_multi_alarm_clock;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic found;

  always #5 clk = ~clk;

  multi_alarm_clock_if #(.NUM_ALARMS(4)) bus ();

  multi_alarm_clock #(
    .CLK_HZ(4), .SET_RATE_HZ(2), .NUM_ALARMS(4), .SNOOZE_MIN(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sec0(input string tag);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (bus.sec == 6'd0) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.run       = 1'b1;
    bus.time_set  = 1'b0;
    bus.alarm_set = 1'b0;
    bus.set_hr    = 1'b0;
    bus.alarm_idx = '0;
    bus.alarm_en  = '0;
    bus.alarm_ack = 1'b0;
`ifdef SNOOZE_EN
    bus.snooze    = 1'b0;
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // 1: reset mid-count, then tick cadence
    cyc(6);
    check("pre_reset_sec", 32'(bus.sec), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_time", 32'({bus.hrs, bus.min, bus.sec}), 32'd0);
    check("rst_alarm_disp", 32'({bus.a_hrs, bus.a_min}), 32'd0);
    check("rst_ringing", 32'({bus.ringing, bus.alarm_out}), 32'd0);
    check("rst_tick", 32'(bus.tick_1hz), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", k), 32'(bus.tick_1hz), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    check("run_sec3", 32'(bus.sec), 32'd3);

    // 2: preload 23:59, run to 23:59:58 and across midnight
    bus.time_set = 1'b1; bus.set_hr = 1'b1; cyc(46);
    bus.set_hr = 1'b0; cyc(118);
    check("preload_2359", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd23, 6'd59, 6'd0}));
    bus.time_set = 1'b0; cyc(232);
    check("t_235958", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd23, 6'd59, 6'd58}));
    cyc(4);
    check("t_235959", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd23, 6'd59, 6'd59}));
    cyc(4);
    check("t_midnight", 32'({bus.hrs, bus.min, bus.sec}), 32'd0);

    // 3: set minutes wrap without carry into hours
    bus.time_set = 1'b1; bus.set_hr = 1'b1; cyc(10);
    bus.set_hr = 1'b0; cyc(118);
    check("set_0559", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd5, 6'd59, 6'd0}));
    cyc(2);
    check("set_wrap_nocarry", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd5, 6'd0, 6'd0}));

    // 4: alarm 2 at 06:30
    bus.set_hr = 1'b1; cyc(2);
    bus.set_hr = 1'b0; cyc(58);
    bus.time_set = 1'b0; bus.run = 1'b0;
    bus.alarm_set = 1'b1; bus.alarm_idx = 2'd2; bus.set_hr = 1'b1; cyc(12);
    bus.set_hr = 1'b0; cyc(60);
    check("a2_disp", 32'({bus.a_hrs, bus.a_min}), 32'({5'd6, 6'd30}));
    check("frozen_0629", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd6, 6'd29, 6'd0}));
    bus.alarm_set = 1'b0; bus.alarm_en = 4'b0100; bus.run = 1'b1; cyc(236);
    check("t_062959", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd6, 6'd29, 6'd59}));
    wait_sec0("wait_0630");
    check("t_0630", 32'({bus.hrs, bus.min}), 32'({5'd6, 6'd30}));
    check("ring_latency", 32'(bus.ringing), 32'd0);
    cyc(1);
    check("ring_a2", 32'(bus.ringing), 32'b0100);
    check("alarm_out_a2", 32'(bus.alarm_out), 32'd1);
    bus.alarm_ack = 1'b1; cyc(1);
    check("ack_clear", 32'({bus.ringing, bus.alarm_out}), 32'd0);
    bus.alarm_ack = 1'b0;

    bus.alarm_en = 4'b0000; bus.time_set = 1'b1; cyc(118);
    bus.time_set = 1'b0; cyc(236);
    check("t_062959_b", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd6, 6'd29, 6'd59}));
    wait_sec0("wait_0630_b");
    cyc(1);
    check("disabled_silent", 32'({bus.ringing, bus.alarm_out}), 32'd0);
    check("t_0630_b", 32'({bus.hrs, bus.min}), 32'({5'd6, 6'd30}));

    // 5: alarms 0 and 3 at 07:00, ack held through the match
    bus.time_set = 1'b1; cyc(58);
    bus.time_set = 1'b0; bus.run = 1'b0;
    bus.alarm_set = 1'b1; bus.set_hr = 1'b1; bus.alarm_idx = 2'd0; cyc(14);
    bus.alarm_idx = 2'd3; cyc(14);
    check("a3_disp", 32'({bus.a_hrs, bus.a_min}), 32'({5'd7, 6'd0}));
    bus.alarm_set = 1'b0; bus.set_hr = 1'b0;
    bus.alarm_en = 4'b1001; bus.run = 1'b1; cyc(236);
    check("t_065959", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd6, 6'd59, 6'd59}));
    wait_sec0("wait_0700");
    check("t_0700", 32'({bus.hrs, bus.min}), 32'({5'd7, 6'd0}));
    bus.alarm_ack = 1'b1; cyc(1);
    check("match_beats_ack", 32'(bus.ringing), 32'b1001);
    check("alarm_out_dual", 32'(bus.alarm_out), 32'd1);
    bus.alarm_ack = 1'b0; bus.alarm_idx = 2'd0; cyc(1);
    check("idx_no_effect", 32'(bus.ringing), 32'b1001);
    check("a0_disp", 32'({bus.a_hrs, bus.a_min}), 32'({5'd7, 6'd0}));
    bus.alarm_ack = 1'b1; cyc(1);
    check("ack_dual", 32'({bus.ringing, bus.alarm_out}), 32'd0);
    bus.alarm_ack = 1'b0;

`ifdef SNOOZE_EN
    // 6: ring at 23:58, snooze, re-ring at 00:03
    bus.alarm_en = 4'b0010; bus.run = 1'b0;
    bus.alarm_set = 1'b1; bus.alarm_idx = 2'd1; bus.set_hr = 1'b1; cyc(46);
    bus.set_hr = 1'b0; cyc(116);
    bus.alarm_set = 1'b0; bus.time_set = 1'b1; bus.set_hr = 1'b1; cyc(32);
    bus.set_hr = 1'b0; cyc(114);
    bus.time_set = 1'b0; bus.run = 1'b1; cyc(236);
    check("t_235759", 32'({bus.hrs, bus.min, bus.sec}), 32'({5'd23, 6'd57, 6'd59}));
    wait_sec0("wait_2358");
    cyc(1);
    check("ring_a1", 32'(bus.ringing), 32'b0010);
    bus.snooze = 1'b1; cyc(1);
    check("snooze_clear", 32'(bus.ringing), 32'd0);
    bus.snooze = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 1400 && !found; k++) begin
      @(negedge clk);
      if ({bus.hrs, bus.min, bus.sec} == {5'd0, 6'd3, 6'd0}) found = 1'b1;
    end
    check("wait_0003", 32'(found), 32'd1);
    check("snooze_latency", 32'(bus.ringing), 32'd0);
    cyc(1);
    check("snooze_rering", 32'(bus.ringing), 32'b0010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
